// File: rtl/parking_gate_controller.sv
// Parking gate controller: turns debounced entry/exit button levels into one-shot
// events, tracks free spaces and holds the gate open for a fixed time per car.
module parking_gate_controller #(
    parameter  int CAPACITY    = 8,
    parameter  int OPEN_CYCLES = 1000000,
    localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_btn,
    input  logic             exit_btn,
    output logic             gate_open,
    output logic             gate_dir,
    output logic [CNT_W-1:0] free_count,
    output logic             lot_full,
    output logic             entry_denied
);

    localparam int               TMR_W    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] free_nxt;
    logic             gate_dir_nxt;
    logic             entry_denied_nxt;
    logic             entry_q, exit_q;
    logic             entry_evt, exit_evt;

    // Edge registers reset to 1 so a button already held at reset release is ignored.
    assign entry_evt = entry_btn & ~entry_q;
    assign exit_evt  = exit_btn  & ~exit_q;
    assign lot_full  = (free_count == '0);

    always_comb begin
        state_nxt        = state;
        timer_nxt        = timer;
        free_nxt         = free_count;
        gate_dir_nxt     = gate_dir;
        entry_denied_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (exit_evt && (free_count < CAP_VAL)) begin
                    // Exit wins a same-cycle tie; the simultaneous entry is refused.
                    state_nxt        = OPEN;
                    timer_nxt        = TMR_LOAD;
                    gate_dir_nxt     = 1'b1;
                    free_nxt         = free_count + CNT_W'(1);
                    entry_denied_nxt = entry_evt;
                end else if (entry_evt) begin
                    if (free_count != '0) begin
                        state_nxt    = OPEN;
                        timer_nxt    = TMR_LOAD;
                        gate_dir_nxt = 1'b0;
                        free_nxt     = free_count - CNT_W'(1);
                    end else begin
                        entry_denied_nxt = 1'b1;
                    end
                end
            end
            OPEN: begin
                entry_denied_nxt = entry_evt & lot_full;
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            gate_open    <= 1'b0;
            gate_dir     <= 1'b0;
            free_count   <= CAP_VAL;
            entry_denied <= 1'b0;
            entry_q      <= 1'b1;
            exit_q       <= 1'b1;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            gate_open    <= (state_nxt == OPEN);
            gate_dir     <= gate_dir_nxt;
            free_count   <= free_nxt;
            entry_denied <= entry_denied_nxt;
            entry_q      <= entry_btn;
            exit_q       <= exit_btn;
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios plus random
// button activity, compared every cycle against a cycle-numbered reference model.
module tb_parking_gate_controller;

    localparam int CAP = 3;
    localparam int OC  = 4;

    logic       clk;
    logic       rst;
    logic       entry_btn;
    logic       exit_btn;
    logic       gate_open;
    logic       gate_dir;
    logic [1:0] free_count;
    logic       lot_full;
    logic       entry_denied;

    int checks = 0;
    int errors = 0;

    // Reference model: spaces as an integer, gate as "opened at edge N, open for OC edges".
    int m_free;
    int m_cycle;
    int m_open_at;
    bit m_gate;
    bit m_dir;
    bit m_denied;
    bit m_en_q;
    bit m_ex_q;

    parking_gate_controller #(
        .CAPACITY   (CAP),
        .OPEN_CYCLES(OC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_btn   (entry_btn),
        .exit_btn    (exit_btn),
        .gate_open   (gate_open),
        .gate_dir    (gate_dir),
        .free_count  (free_count),
        .lot_full    (lot_full),
        .entry_denied(entry_denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_free   = CAP;
        m_gate   = 1'b0;
        m_dir    = 1'b0;
        m_denied = 1'b0;
        m_en_q   = 1'b1;
        m_ex_q   = 1'b1;
    endtask

    task automatic model_open(input bit dir);
        m_gate    = 1'b1;
        m_dir     = dir;
        m_open_at = m_cycle;
    endtask

    task automatic model_edge(input bit en, input bit ex);
        bit e_evt;
        bit x_evt;
        bit was_open;
        e_evt    = en && !m_en_q;
        x_evt    = ex && !m_ex_q;
        was_open = m_gate;
        m_en_q   = en;
        m_ex_q   = ex;
        m_cycle++;
        m_denied = 1'b0;
        if (!was_open) begin
            if (x_evt && m_free < CAP) begin
                model_open(1'b1);
                m_free++;
                m_denied = e_evt;
            end else if (e_evt) begin
                if (m_free > 0) begin
                    model_open(1'b0);
                    m_free--;
                end else begin
                    m_denied = 1'b1;
                end
            end
        end else begin
            m_denied = e_evt && (m_free == 0);
            m_gate   = (m_cycle - m_open_at) < OC;
        end
    endtask

    task automatic compare_all();
        check("gate_open", gate_open, m_gate);
        check("gate_dir", gate_dir, m_dir);
        check("free_count", free_count, m_free);
        check("lot_full", lot_full, m_free == 0);
        check("entry_denied", entry_denied, m_denied);
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic step(input bit en, input bit ex);
        entry_btn = en;
        exit_btn  = ex;
        @(posedge clk);
        model_edge(en, ex);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int high;
        bit en;
        bit ex;
        entry_btn = 1'b0;
        exit_btn  = 1'b0;
        rst       = 1'b1;
        m_cycle   = 0;
        m_open_at = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_free", free_count, CAP);

        // First entry, button then held for 20 cycles: one opening of OC cycles.
        step(0, 0);
        high = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0);
            if (i == 0) begin
                check("first_gate", gate_open, 1);
                check("first_dir", gate_dir, 0);
                check("first_free", free_count, 2);
                check("first_full", lot_full, 0);
            end
            high += int'(gate_open);
        end
        check("held_one_event", high, OC);
        check("held_free", free_count, 2);
        step(0, 0);

        // Two more entries 10 cycles apart; a press during the last opening is refused.
        for (int k = 0; k < 2; k++) begin
            step(1, 0);
            step(0, 0);
            step(1, 0);
            check("press_while_open", entry_denied, k == 1);
            repeat (7) step(0, 0);
        end
        check("full_free", free_count, 0);
        check("full_flag", lot_full, 1);

        step(1, 0);
        check("denied_pulse", entry_denied, 1);
        check("denied_gate", gate_open, 0);
        step(0, 0);
        check("denied_once", entry_denied, 0);
        check("denied_free", free_count, 0);

        // Exit from a full lot, then a simultaneous entry/exit with one space free.
        step(0, 1);
        check("exit0_dir", gate_dir, 1);
        check("exit0_free", free_count, 1);
        repeat (6) step(0, 0);
        step(1, 1);
        check("tie_free", free_count, 2);
        check("tie_dir", gate_dir, 1);
        check("tie_denied", entry_denied, 1);
        repeat (6) step(0, 0);

        // Entry down to one free space, then an exit with free_count == 1.
        step(1, 0);
        repeat (6) step(0, 0);
        check("pre_exit_free", free_count, 1);
        step(0, 1);
        check("exit1_gate", gate_open, 1);
        check("exit1_dir", gate_dir, 1);
        check("exit1_free", free_count, 2);
        repeat (6) step(0, 0);

        // Fill back to capacity; a further exit must be ignored.
        step(0, 1);
        repeat (6) step(0, 0);
        check("empty_free", free_count, CAP);
        step(0, 1);
        check("exit_empty_gate", gate_open, 0);
        check("exit_empty_free", free_count, CAP);
        repeat (3) step(0, 0);

        // Entry button held across reset release: no event.
        entry_btn = 1'b1;
        do_reset();
        repeat (5) step(1, 0);
        check("held_rst_gate", gate_open, 0);
        check("held_rst_free", free_count, CAP);

        // Reset asserted during the second open cycle.
        step(0, 0);
        step(1, 0);
        step(1, 0);
        check("mid_open_before", gate_open, 1);
        do_reset();
        check("mid_open_gate", gate_open, 0);
        check("mid_open_free", free_count, CAP);

        // Random button activity against the model.
        en = 1'b0;
        ex = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) en = ~en;
            if ($urandom_range(0, 4) == 0) ex = ~ex;
            step(en, ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
